hub_linear_fold_ctrl: RTL and testbench

Sequencer for the folded hybrid-unary linear layer datapath. It handshakes weight loading, then steps the fold partition index through every part. Each part gets one full bitstream window plus a pipeline-drain window. At the end of each frame it swaps the double accumulation buffer and flags the output frame as valid. It drives the datapath's `load`, `sel`, `clear` and `part` inputs and sits between the layer-level scheduler and one folded linear datapath.

---
 rtl/hub_linear_fold_ctrl_pkg.sv | 12 +
 rtl/hub_linear_fold_ctrl_fold_cnt.sv | 57 +++++
 rtl/hub_linear_fold_ctrl.sv | 102 ++++++++++
 tb/tb_hub_linear_fold_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/hub_linear_fold_ctrl_pkg.sv
// Shared types for the folded hybrid-unary linear layer controller.
package hub_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_SWAP
  } ctrl_state_t;

endpackage

// File: rtl/hub_linear_fold_ctrl_fold_cnt.sv
// In-part cycle counter and fold partition index. The window covers the
// bitstream cycles plus the adder-tree drain cycles.
module fold_cnt #(
  parameter int FOLD = 1,
  parameter int PWID = 1,
  parameter int RWID = 10,
  parameter int LAT  = 2,
  parameter int CWID = $clog2((2**RWID) + LAT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  output logic [CWID-1:0] cnt,
  output logic [PWID-1:0] part,
  output logic            part_last,
  output logic            win_last
);

  localparam int WIN = (2**RWID) + LAT;

  logic [CWID-1:0] cnt_q, cnt_d;
  logic [PWID-1:0] part_q, part_d;

  assign cnt       = cnt_q;
  assign part      = part_q;
  assign win_last  = (cnt_q == CWID'(WIN - 1));
  assign part_last = (part_q == PWID'(FOLD - 1));

  always_comb begin
    cnt_d  = cnt_q;
    part_d = part_q;
    if (clr) begin
      cnt_d  = '0;
      part_d = '0;
    end else if (en) begin
      if (win_last) begin
        cnt_d = '0;
        // The last part holds its index; leaving SWAP clears it.
        if (!part_last) part_d = part_q + PWID'(1);
      end else begin
        cnt_d = cnt_q + CWID'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      part_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      part_q <= part_d;
    end
  end

endmodule

// File: rtl/hub_linear_fold_ctrl.sv
// Frame sequencer for one folded linear datapath: weight-load handshake,
// per-part bitstream + drain windows, and double-buffer swap per frame.
module hub_linear_fold_ctrl
  import hub_ctrl_pkg::*;
#(
  parameter int FOLD = 1,
  parameter int PWID = ($clog2(FOLD) < 2) ? 1 : $clog2(FOLD),
  parameter int RWID = 10,
  parameter int LAT  = 2,
  parameter int CWID = $clog2((2**RWID) + LAT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iStart,
  input  logic            iStop,
  input  logic            iWValid,
  output logic            oWReady,
  output logic            oLoad,
  output logic            oSel,
  output logic            oClear,
  output logic [PWID-1:0] oPart,
  output logic            oBusy,
  output logic            oOValid
);

  localparam int CYC = 2**RWID;

  ctrl_state_t     state_q, state_d;
  logic            sel_q, sel_d;
  logic [CWID-1:0] cnt;
  logic [PWID-1:0] part;
  logic            part_last, win_last, run_last;
  logic            cnt_en, cnt_clr;

  assign run_last = (cnt == CWID'(CYC - 1));
  assign cnt_en   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  // Every path into RUN passes through IDLE, LOAD or SWAP, so clearing
  // there guarantees part=0/cnt=0 on RUN entry.
  assign cnt_clr  = iStop || (state_q == ST_IDLE) || (state_q == ST_LOAD) ||
                    (state_q == ST_SWAP);

  fold_cnt #(
    .FOLD (FOLD),
    .PWID (PWID),
    .RWID (RWID),
    .LAT  (LAT),
    .CWID (CWID)
  ) u_fold_cnt (
    .clk       (clk),
    .rst       (rst),
    .en        (cnt_en),
    .clr       (cnt_clr),
    .cnt       (cnt),
    .part      (part),
    .part_last (part_last),
    .win_last  (win_last)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    unique case (state_q)
      ST_IDLE, ST_SWAP: begin
        if (iStart) state_d = iWValid ? ST_LOAD : ST_RUN;
        else        state_d = ST_IDLE;
      end
      ST_LOAD: begin
        if (iWValid) state_d = ST_RUN;
      end
      ST_RUN: begin
        // With LAT=0 the window ends inside RUN, so check it first.
        if (win_last)      state_d = part_last ? ST_SWAP : ST_RUN;
        else if (run_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (win_last) state_d = part_last ? ST_SWAP : ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    if (iStop) state_d = ST_IDLE;
    if ((state_d == ST_SWAP) && (state_q != ST_SWAP)) sel_d = ~sel_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  assign oWReady = (state_q == ST_LOAD);
  assign oLoad   = (state_q == ST_LOAD) && iWValid && !iStop;
  assign oSel    = sel_q;
  assign oClear  = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_SWAP);
  assign oPart   = part;
  assign oBusy   = (state_q != ST_IDLE);
  assign oOValid = (state_q == ST_SWAP);

endmodule

// File: tb/tb_hub_linear_fold_ctrl.sv
// Directed bench: FOLD=2/RWID=3/LAT=2 main instance plus a FOLD=1/LAT=0 variant.
module tb_hub_linear_fold_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic start, wv, stop;
  logic wready, load, sel, clr, busy, ovalid;
  logic [0:0] part;

  logic start2, wv2, stop2;
  logic wready2, load2, sel2, clr2, busy2, ovalid2;
  logic [0:0] part2;

  hub_linear_fold_ctrl #(.FOLD(2), .RWID(3), .LAT(2)) dut (
    .clk(clk), .rst(rst), .iStart(start), .iStop(stop), .iWValid(wv),
    .oWReady(wready), .oLoad(load), .oSel(sel), .oClear(clr),
    .oPart(part), .oBusy(busy), .oOValid(ovalid)
  );

  hub_linear_fold_ctrl #(.FOLD(1), .RWID(3), .LAT(0)) dut2 (
    .clk(clk), .rst(rst), .iStart(start2), .iStop(stop2), .iWValid(wv2),
    .oWReady(wready2), .oLoad(load2), .oSel(sel2), .oClear(clr2),
    .oPart(part2), .oBusy(busy2), .oOValid(ovalid2)
  );

  // {wready, load, sel, clear, busy, ovalid}
  logic [5:0] obs;
  assign obs = {wready, load, sel, clr, busy, ovalid};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       st;
    logic       wv;
    logic       sp;
    logic [5:0] exp;
  } vec_t;

  function automatic vec_t mkv(logic s, logic w, logic p, logic [5:0] e);
    vec_t v;
    v.st = s; v.wv = w; v.sp = p; v.exp = e;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[13];

  initial begin
    // IDLE=000100, LOAD stall=100110, LOAD handshake=110110, RUN=000010
    tbl[0]  = mkv(0, 0, 0, 6'b000100);
    tbl[1]  = mkv(0, 0, 0, 6'b000100);
    tbl[2]  = mkv(1, 1, 0, 6'b000100);
    tbl[3]  = mkv(0, 0, 0, 6'b100110);
    tbl[4]  = mkv(0, 0, 0, 6'b100110);
    tbl[5]  = mkv(0, 0, 0, 6'b100110);
    tbl[6]  = mkv(0, 0, 0, 6'b100110);
    tbl[7]  = mkv(0, 1, 0, 6'b110110);
    tbl[8]  = mkv(0, 0, 0, 6'b000010);
    tbl[9]  = mkv(0, 0, 1, 6'b000010);
    tbl[10] = mkv(1, 1, 0, 6'b000100);
    tbl[11] = mkv(0, 1, 1, 6'b100110);
    tbl[12] = mkv(0, 0, 0, 6'b000100);

    rst = 1'b1;
    start = 0; wv = 0; stop = 0;
    start2 = 0; wv2 = 0; stop2 = 0;
    #1;
    chk("reset_outputs", {9'd0, obs, part}, {9'd0, 6'b000100, 1'b0});
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      #1 chk("idle", {9'd0, obs, part}, {9'd0, 6'b000100, 1'b0});
      step();
    end

    for (int i = 0; i < 13; i++) begin
      start = tbl[i].st; wv = tbl[i].wv; stop = tbl[i].sp;
      #1 chk($sformatf("tbl[%0d]", i), {9'd0, obs, part}, {9'd0, tbl[i].exp, 1'b0});
      step();
    end
    start = 0; wv = 0; stop = 0;

    // Load-then-run frame, followed back-to-back by a no-reload frame.
    start = 1; wv = 1;
    #1 chk("a_idle", {10'd0, obs}, {10'd0, 6'b000100});
    step();
    start = 0;
    #1 chk("a_load", {10'd0, obs}, {10'd0, 6'b110110});
    step();
    wv = 0; start = 1;
    for (int k = 0; k < 42; k++) begin
      if (k == 41) start = 0;
      #1;
      if (k == 20)
        chk($sformatf("a_swap1 k=%0d", k), {10'd0, obs}, {10'd0, 6'b001111});
      else if (k == 41)
        chk($sformatf("a_swap2 k=%0d", k), {10'd0, obs}, {10'd0, 6'b000111});
      else begin
        chk($sformatf("a_run k=%0d", k), {10'd0, obs},
            {10'd0, 2'b00, (k > 20), 3'b010});
        chk($sformatf("a_part k=%0d", k), {15'd0, part},
            {15'd0, 1'((((k < 20) ? k : k - 21)) / 10)});
      end
      step();
    end
    #1 chk("a_idle_after", {10'd0, obs}, {10'd0, 6'b000100});

    // Single frame without reload: oSel ends at 1.
    start = 1;
    step();
    start = 0;
    for (int k = 0; k < 21; k++) begin
      #1;
      if (k == 20) chk("b_swap", {10'd0, obs}, {10'd0, 6'b001111});
      else         chk($sformatf("b_run k=%0d", k), {10'd0, obs}, {10'd0, 6'b000010});
      step();
    end
    #1 chk("b_idle", {10'd0, obs}, {10'd0, 6'b001100});

    // Stop at cycle 5 of part 1.
    start = 1;
    step();
    start = 0;
    for (int k = 0; k < 16; k++) begin
      if (k == 15) stop = 1;
      #1 chk($sformatf("c_run k=%0d", k), {9'd0, obs, part},
             {9'd0, 6'b001010, 1'(k / 10)});
      step();
    end
    stop = 0;
    #1 chk("c_stop_idle", {9'd0, obs, part}, {9'd0, 6'b001100, 1'b0});
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("c_no_ovalid k=%0d", k), {15'd0, ovalid}, 16'd0);
    end

    // Asynchronous reset mid-DRAIN.
    start = 1;
    step();
    start = 0;
    for (int k = 0; k < 9; k++) begin
      #1 chk($sformatf("d_run k=%0d", k), {10'd0, obs}, {10'd0, 6'b001010});
      if (k < 8) step();
    end
    #2 rst = 1'b1;
    #1 chk("d_async_rst", {9'd0, obs, part}, {9'd0, 6'b000100, 1'b0});
    #1 rst = 1'b0;
    step();
    #1 chk("d_idle_after_rst", {9'd0, obs, part}, {9'd0, 6'b000100, 1'b0});

    // FOLD=1, LAT=0: SWAP every 9 cycles with iStart held.
    start2 = 1;
    for (int c = 0; c < 36; c++) begin
      #1 chk($sformatf("e_fold1 c=%0d", c), {13'd0, ovalid2, part2, busy2},
             {13'd0, (c > 0) && (c % 9 == 0), 1'b0, (c > 0)});
      step();
    end
    start2 = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
